// File: rtl/gate_selftest_ctrl_if.sv
// Handshake bundle between a higher-level test controller and gate_selftest_ctrl.
// The master side issues start; the slave side (the sequencer) reports status and results.
interface gate_selftest_ctrl_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_cnt;
   logic [1:0] fail_vec;
   logic       fail_valid;

   modport master (
      output start,
      input  busy, done, pass, err_cnt, fail_vec, fail_valid
   );

   modport slave (
      input  start,
      output busy, done, pass, err_cnt, fail_vec, fail_valid
   );
endinterface

// File: rtl/gate_selftest_ctrl.sv
// Built-in self-test sequencer for one 2-input gate: applies 00,01,10,11, checks y against EXP_TT.
// Define GATE_SELFTEST_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module gate_selftest_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  EXP_TT        = 4'b0111
) (
   input  logic                 clk,
   input  logic                 rst,
   gate_selftest_ctrl_if.slave  ctl,
   input  logic                 y,
   output logic                 a,
   output logic                 b
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_r;
   logic [1:0] vec_r;
   logic [3:0] cnt_r;
   logic       a_r;
   logic       b_r;
   logic       busy_r;
   logic       done_r;
   logic       pass_r;
   logic [2:0] err_r;
   logic [1:0] fail_vec_r;
   logic       fail_valid_r;
   logic [1:0] vec_next_s;
   logic       mismatch_s;

   // Case equality so an X/Z on y is treated as a failure rather than masked.
   assign mismatch_s = (y !== EXP_TT[vec_r]);
   assign vec_next_s = vec_r + 2'd1;

   // Sequencer state, gate stimulus and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         vec_r        <= 2'd0;
         cnt_r        <= 4'd0;
         a_r          <= 1'b0;
         b_r          <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         err_r        <= 3'd0;
         fail_vec_r   <= 2'd0;
         fail_valid_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (ctl.start) begin
                  state_r      <= ST_SETTLE;
                  vec_r        <= 2'd0;
                  cnt_r        <= 4'd0;
                  a_r          <= 1'b0;
                  b_r          <= 1'b0;
                  busy_r       <= 1'b1;
                  pass_r       <= 1'b0;
                  err_r        <= 3'd0;
                  fail_vec_r   <= 2'd0;
                  fail_valid_r <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SETTLE: begin
               cnt_r <= cnt_r + 4'd1;
               if (cnt_r == SETTLE_LAST) begin
                  state_r <= ST_CHECK;
               end else begin
                  state_r <= ST_SETTLE;
               end
            end
            ST_CHECK: begin
               if (mismatch_s) begin
                  err_r <= err_r + 3'd1;
                  if (!fail_valid_r) begin
                     fail_vec_r   <= vec_r;
                     fail_valid_r <= 1'b1;
                  end
               end
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
               if (mismatch_s || (vec_r == 2'd3)) begin
`else
               if (vec_r == 2'd3) begin
`endif
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_SETTLE;
                  vec_r   <= vec_next_s;
                  a_r     <= vec_next_s[1];
                  b_r     <= vec_next_s[0];
                  cnt_r   <= 4'd0;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b1;
               pass_r  <= (err_r == 3'd0);
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign a              = a_r;
   assign b              = b_r;
   assign ctl.busy       = busy_r;
   assign ctl.done       = done_r;
   assign ctl.pass       = pass_r;
   assign ctl.err_cnt    = err_r;
   assign ctl.fail_vec   = fail_vec_r;
   assign ctl.fail_valid = fail_valid_r;

endmodule

// File: doc/gate_selftest_ctrl.md
Name: gate_selftest_ctrl

Overview:
Sequencer that exercises one 2-input combinational gate (default: nand_gate) through all four input vectors and checks each output against a parameterised truth table. Drives the gate's a/b inputs, waits a settle interval, samples y, and accumulates an error count plus the first failing vector. Sits beside the gate under a start/busy/done handshake so a higher-level test controller can run built-in self-test on demand.

Parameters:
SETTLE_CYCLES, 2, cycles a/b are held before y is sampled; legal range 1..15 (4-bit counter)
EXP_TT, 4'b0111, expected y per vector; bit index = {a,b}; default is NAND (11->0, else 1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a test run; sampled only in IDLE
y  input  1  output of the gate under test
a  output  1  gate input A, registered
b  output  1  gate input B, registered
busy  output  1  high from the cycle after start is accepted through the last CHECK
done  output  1  one-cycle pulse at run completion
pass  output  1  high when last completed run had err_cnt==0; held until next accepted start
err_cnt  output  3  mismatches in current/last run, 0..4
fail_vec  output  2  {a,b} of first mismatching vector; valid when fail_valid=1
fail_valid  output  1  at least one mismatch recorded in current/last run

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_valid=0, vec=0, settle counter=0. Applies mid-run: run aborted, no done pulse.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 -> SETTLE; same edge loads vec=0, a=0, b=0, busy=1, clears pass/err_cnt/fail_vec/fail_valid, settle counter=0.
- SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE -> CHECK.
- CHECK (one cycle): y compared with EXP_TT[vec] using case equality (X/Z on y counts as mismatch). Mismatch: err_cnt+1; if fail_valid=0 then fail_vec=vec, fail_valid=1. If vec==3 -> DONE, busy=0. Else vec+1, a=vec_next[1], b=vec_next[0], counter=0 -> SETTLE.
- DONE (one cycle): done=1, pass=(err_cnt==0); -> IDLE. a/b hold last vector (1,1) until next start.
- Latency: start sampled at cycle 0; vector k checked at cycle (k+1)*(SETTLE_CYCLES+1); done high at cycle 4*(SETTLE_CYCLES+1)+1. Default: checks at 3,6,9,12; done at 13.
- start while not IDLE ignored; start held high continuously re-triggers a new run the cycle after DONE.
- err_cnt saturates naturally at 4 (never wraps); no other arithmetic.

Optional Feature:
GATE_SELFTEST_STOP_ON_FAIL_EN: when defined, a mismatch in CHECK goes straight to DONE (busy=0) without applying remaining vectors; err_cnt=1, pass=0, done pulses the following cycle. When undefined, all four vectors are always applied and err_cnt reports total mismatches.

Test Plan:
- Reset then start=1 one cycle, y from nand_gate, SETTLE_CYCLES=2 -> a/b sequence 00,01,10,11; done at cycle 13; pass=1, err_cnt=0, fail_valid=0.
- y from AND gate, EXP_TT=4'b0111 -> err_cnt=4, fail_vec=2'b00, fail_valid=1, pass=0, done at cycle 13.
- y forced 1 (stuck-at-1) -> only vector 11 mismatches; err_cnt=1, fail_vec=2'b11, pass=0.
- start pulsed at cycles 4 and 8 during a run -> ignored; single done at cycle 13; then start again -> pass/err_cnt cleared at accept, second done 14 cycles later.
- rst=1 at cycle 7 mid-run -> next cycle all outputs at reset values, no done pulse; new start runs cleanly to pass=1.
- With GATE_SELFTEST_STOP_ON_FAIL_EN, AND gate as y -> mismatch at vector 00 in cycle 3, done at cycle 4, err_cnt=1, fail_vec=2'b00.
